full_adder: RTL and testbench
=============================

// Module: full_adder
// PURPOSE
//   Registered unsigned WIDTH-bit adder producing sum and carry-out.
//   Built as a ripple chain of 1-bit full-adder cells (generate loop), then an output register stage.
//   Serves as the basic accumulate/add primitive for the neural-network datapath (neuron partial sums).
//   One clock domain; synchronous active-high reset.
// PARAMETERS
//   WIDTH     8   operand/result width in bits (legal range >= 1)
// PORTS
//   clk        input   1      rising-edge clock; all state updates on this edge
//   rst        input   1      synchronous reset, active-high
//   in_valid   input   1      operands/cin valid this cycle
//   operand_1  input   WIDTH  addend A, unsigned
//   operand_2  input   WIDTH  addend B, unsigned
//   cin        input   1      carry-in; tie 0 for plain A+B
//   co         output  1      carry-out of the registered sum
//   result     output  WIDTH  registered sum, low WIDTH bits of A+B+cin
//   overflow   output  1      two's-complement signed overflow of the registered sum
//   zero       output  1      1 when registered result == 0
//   out_valid  output  1      result/co/overflow/zero hold a new sum this cycle
// BEHAVIOUR
//   - Reset: clk and rst are fixed as one clock; reset is synchronous and active-high.
//     At any rising edge with rst=1: result=0, co=0, overflow=0, zero=1, out_valid=0.
//     rst has priority over in_valid.
//   - Core: combinational ripple, s[i] = a[i]^b[i]^c[i], c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]), c[0]=cin.
//   - Flags: {co,result} = operand_1 + operand_2 + cin, exact (WIDTH+1)-bit result.
//     overflow = c[WIDTH] ^ c[WIDTH-1].
//     zero = (result == 0), evaluated on the registered value.
//   - Latency: 1 clock. Edge with in_valid=1 and rst=0: result, co, overflow and zero load the new sum, out_valid=1.
//   - Edge with in_valid=0 and rst=0: out_valid=0; result, co, overflow and zero hold their previous values.
//   - Throughput: one add per clock; back-to-back in_valid allowed; no backpressure.
//   - Wrap-around: results that exceed 2^WIDTH-1 wrap modulo 2^WIDTH, with co=1.
//   - Boundaries:
//     - all-ones + 0 + cin=1 -> result=0, co=1, zero=1.
//     - 0 + 0 + 0 -> zero=1, co=0.
//   - Reset mid-stream: an operand presented on the same edge as rst=1 is discarded. The next valid sum appears one cycle after rst deasserts.
//   - Inputs are sampled only at clock edges; X on operands while in_valid=0 must not propagate to outputs.
// TESTING
//   - Reset: rst=1 for 2 cycles -> result=0, co=0, zero=1, out_valid=0.
//   - Basic adds, WIDTH=8, cin=0, one result per cycle each 1 cycle later, all with co=0, out_valid=1:
//     2+3 -> 5; 12+3 -> 15; 0+1 -> 1 (zero=0).
//   - Carry/wrap: 255+1 -> result=0, co=1, zero=1. 200+100 -> result=44, co=1.
//   - Signed overflow and cin:
//     127+1 -> result=128, overflow=1, co=0. 128+128 -> result=0, co=1, overflow=1.
//     254+0 with cin=1 -> 255, co=0.
//   - Valid/hold:
//     in_valid pulses 1,0,1 with 5+5 then 7+8 -> out_valid 1,0,1; result 10, stays 10, then 15.
//     rst=1 on the same edge as in_valid=1 -> operand dropped, outputs at reset values.
//   - Random: 1000 random A/B/cin vectors -> {co,result} == A+B+cin every cycle, checked against a reference model.

Source files
------------

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple adder.
// master drives operands, slave (the adder) returns the registered sum.
interface full_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic             cin;
    logic             co;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, operand_1, operand_2, cin,
        input  co, result, overflow, zero, out_valid
    );

    modport slave (
        input  in_valid, operand_1, operand_2, cin,
        output co, result, overflow, zero, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered unsigned WIDTH-bit adder: ripple chain of 1-bit cells,
// then one output register stage with carry, signed overflow and zero flags.
module full_adder #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    full_adder_if.slave bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p      = bus.operand_1[i] ^ bus.operand_2[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (bus.operand_1[i] & bus.operand_2[i]) | (c[i] & p);
    end

    // Flags only load with a valid sum, so X on idle operands never escapes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result    <= '0;
            bus.co        <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result   <= s;
                bus.co       <= c[WIDTH];
                bus.overflow <= c[WIDTH] ^ c[WIDTH-1];
                bus.zero     <= (s == '0);
            end
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of the registered ripple adder.
// Observed vector packs {co, overflow, zero, out_valid, result}.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    full_adder_if #(.WIDTH(8)) bus ();

    full_adder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {bus.co, bus.overflow, bus.zero, bus.out_valid, bus.result};

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic v);
        bus.operand_1 = a;
        bus.operand_2 = b;
        bus.cin       = c;
        bus.in_valid  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(8'd0, 8'd0, 1'b0, 1'b0);
            total_cnt++;
            if (obs !== 12'b0010_0000_0000)
                $display("FAIL reset_cyc%0d got %h want %h", i, obs, 12'h200);
            else
                pass_cnt++;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0]  a [3] = '{8'd2, 8'd12, 8'd0};
        logic [7:0]  b [3] = '{8'd3, 8'd3, 8'd1};
        logic [11:0] e [3] = '{12'h105, 12'h10f, 12'h101};
        for (int i = 0; i < 3; i++) begin
            drive(a[i], b[i], 1'b0, 1'b1);
            total_cnt++;
            if (obs !== e[i])
                $display("FAIL basic_%0d got %h want %h", i, obs, e[i]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_carry;
        drive(8'd255, 8'd1, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== 12'b1011_0000_0000)
            $display("FAIL carry_255p1 got %h want %h", obs, 12'hb00);
        else
            pass_cnt++;
        drive(8'd200, 8'd100, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== {4'b1001, 8'd44})
            $display("FAIL carry_200p100 got %h want %h", obs, {4'b1001, 8'd44});
        else
            pass_cnt++;
        drive(8'd255, 8'd0, 1'b1, 1'b1);
        total_cnt++;
        if (obs !== 12'b1011_0000_0000)
            $display("FAIL carry_ones_cin got %h want %h", obs, 12'hb00);
        else
            pass_cnt++;
    endtask

    task automatic test_overflow;
        drive(8'd127, 8'd1, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== {4'b0101, 8'd128})
            $display("FAIL ovf_127p1 got %h want %h", obs, {4'b0101, 8'd128});
        else
            pass_cnt++;
        drive(8'd128, 8'd128, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== {4'b1111, 8'd0})
            $display("FAIL ovf_128p128 got %h want %h", obs, {4'b1111, 8'd0});
        else
            pass_cnt++;
        drive(8'd254, 8'd0, 1'b1, 1'b1);
        total_cnt++;
        if (obs !== {4'b0001, 8'd255})
            $display("FAIL cin_254 got %h want %h", obs, {4'b0001, 8'd255});
        else
            pass_cnt++;
        drive(8'd0, 8'd0, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== {4'b0011, 8'd0})
            $display("FAIL zero_0p0 got %h want %h", obs, {4'b0011, 8'd0});
        else
            pass_cnt++;
    endtask

    task automatic test_valid_hold;
        drive(8'd5, 8'd5, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== {4'b0001, 8'd10})
            $display("FAIL hold_first got %h want %h", obs, {4'b0001, 8'd10});
        else
            pass_cnt++;
        drive('x, 'x, 1'bx, 1'b0);
        total_cnt++;
        if (obs !== {4'b0000, 8'd10})
            $display("FAIL hold_idle got %h want %h", obs, {4'b0000, 8'd10});
        else
            pass_cnt++;
        drive(8'd7, 8'd8, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== {4'b0001, 8'd15})
            $display("FAIL hold_second got %h want %h", obs, {4'b0001, 8'd15});
        else
            pass_cnt++;
    endtask

    task automatic test_reset_midstream;
        rst = 1'b1;
        drive(8'd9, 8'd9, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== 12'b0010_0000_0000)
            $display("FAIL mid_rst got %h want %h", obs, 12'h200);
        else
            pass_cnt++;
        rst = 1'b0;
        drive(8'd3, 8'd4, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== {4'b0001, 8'd7})
            $display("FAIL mid_after got %h want %h", obs, {4'b0001, 8'd7});
        else
            pass_cnt++;
    endtask

    task automatic test_random;
        logic [7:0]  a, b;
        logic        c;
        logic [8:0]  sum;
        logic        ov;
        logic [11:0] e;
        int          sv;
        for (int i = 0; i < 1000; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            c   = 1'($urandom_range(0, 1));
            sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
            sv  = int'($signed(a)) + int'($signed(b)) + int'(c);
            ov  = (sv > 127) || (sv < -128);
            e   = {sum[8], ov, sum[7:0] == 8'd0, 1'b1, sum[7:0]};
            drive(a, b, c, 1'b1);
            total_cnt++;
            if (obs !== e)
                $display("FAIL rand_%0d a=%0d b=%0d cin=%0d got %h want %h",
                         i, a, b, c, obs, e);
            else
                pass_cnt++;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.cin       = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_valid_hold();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
